// File: rtl/ifu_fetch_ctrl.sv
// Fetch-stage sequencer: paces the IFU against a variable-latency imem,
// arbitrates hazard stalls against CP0 redirects and drives the pipeline flushes.
module ifu_fetch_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_stall,
  input  logic             exc_req,
  input  logic             eret_in,
  input  logic [31:0]      epc,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             ifu_en,
  output logic             ifu_req,
  output logic             ifu_eret,
  output logic [31:0]      epc_out,
  output logic             flush_fd,
  output logic             flush_de,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    REDIR = 3'd4
  } state_t;

  typedef enum logic {
    KIND_ERET = 1'b0,
    KIND_EXC  = 1'b1
  } kind_t;

  state_t cur_state;
  state_t nxt_state;
  logic   pend_valid;
  logic   pend_valid_nxt;
  kind_t  pend_kind;
  kind_t  pend_kind_nxt;
  logic   epc_load;
  logic   cnt_en;
  logic   redir;
  kind_t  redir_kind;

  // An exception outranks an eret raised in the same cycle.
  assign redir      = exc_req | eret_in;
  assign redir_kind = exc_req ? KIND_EXC : KIND_ERET;
  assign state      = cur_state;

  // REDIR strobes are registered from the next-state decode so they leave a flop cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state  <= BOOT;
      pend_valid <= 1'b0;
      pend_kind  <= KIND_ERET;
      ifu_req    <= 1'b0;
      ifu_eret   <= 1'b0;
      flush_de   <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      pend_valid <= pend_valid_nxt;
      pend_kind  <= pend_kind_nxt;
      ifu_req    <= (nxt_state == REDIR) && pend_valid_nxt && (pend_kind_nxt == KIND_EXC);
      ifu_eret   <= (nxt_state == REDIR) && pend_valid_nxt && (pend_kind_nxt == KIND_ERET);
      flush_de   <= (nxt_state == REDIR);
    end
  end

  always_comb begin
    nxt_state      = cur_state;
    pend_valid_nxt = pend_valid;
    pend_kind_nxt  = pend_kind;
    epc_load       = 1'b0;
    case (cur_state)
      BOOT: nxt_state = FETCH;
      FETCH: begin
        if (redir) begin
          pend_valid_nxt = 1'b1;
          pend_kind_nxt  = redir_kind;
          epc_load       = eret_in & ~exc_req;
          // An outstanding fetch must complete before the PC can move.
          nxt_state      = imem_ready ? REDIR : DRAIN;
        end else if (imem_ready && hz_stall) begin
          nxt_state = HOLD;
        end
      end
      HOLD: begin
        if (redir) begin
          pend_valid_nxt = 1'b1;
          pend_kind_nxt  = redir_kind;
          epc_load       = eret_in & ~exc_req;
          nxt_state      = REDIR;
        end else if (!hz_stall) begin
          nxt_state = FETCH;
        end
      end
      DRAIN: begin
        if (exc_req) pend_kind_nxt = KIND_EXC;
        if (imem_ready) nxt_state = REDIR;
      end
      REDIR: begin
        pend_valid_nxt = 1'b0;
        pend_kind_nxt  = KIND_ERET;
        nxt_state      = FETCH;
      end
      default: nxt_state = BOOT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ifu_en   = 1'b0;
    flush_fd = 1'b0;
    cnt_en   = 1'b0;
    case (cur_state)
      FETCH: begin
        imem_req = 1'b1;
        flush_fd = ~imem_ready;
        if (imem_ready && !hz_stall && !redir) begin
          ifu_en = 1'b1;
          cnt_en = 1'b1;
        end
      end
      HOLD: begin
        if (!hz_stall && !redir) begin
          ifu_en = 1'b1;
          cnt_en = 1'b1;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        flush_fd = 1'b1;
      end
      REDIR: begin
        ifu_en   = 1'b1;
        flush_fd = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      epc_out   <= 32'h0;
    end else begin
      if (cnt_en) fetch_cnt <= fetch_cnt + CNT_W'(1);
      if (epc_load) epc_out <= epc;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl: per-cycle expectations are queued as stimulus
// is driven and compared mid-cycle; a CNT_W=4 twin checks counter wrap.
module tb_ifu_fetch_ctrl;

  localparam logic [2:0] BOOT = 3'd0, FETCH = 3'd1, HOLD = 3'd2, DRAIN = 3'd3, REDIR = 3'd4;

  logic        clk;
  logic        reset;
  logic        hz_stall, exc_req, eret_in, imem_ready;
  logic [31:0] epc;
  logic        imem_req, ifu_en, ifu_req, ifu_eret, flush_fd, flush_de;
  logic [31:0] epc_out, fetch_cnt;
  logic [2:0]  state;

  logic        imem_req4, ifu_en4, ifu_req4, ifu_eret4, flush_fd4, flush_de4;
  logic [31:0] epc_out4;
  logic [3:0]  fetch_cnt4;
  logic [2:0]  state4;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [5:0]  fl;
    logic [31:0] cnt;
    logic [31:0] epc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = 0;
  logic [31:0] exp_epc = 0;

  ifu_fetch_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .exc_req(exc_req), .eret_in(eret_in),
    .epc(epc), .imem_ready(imem_ready), .imem_req(imem_req), .ifu_en(ifu_en),
    .ifu_req(ifu_req), .ifu_eret(ifu_eret), .epc_out(epc_out), .flush_fd(flush_fd),
    .flush_de(flush_de), .fetch_cnt(fetch_cnt), .state(state)
  );

  ifu_fetch_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .exc_req(exc_req), .eret_in(eret_in),
    .epc(epc), .imem_ready(imem_ready), .imem_req(imem_req4), .ifu_en(ifu_en4),
    .ifu_req(ifu_req4), .ifu_eret(ifu_eret4), .epc_out(epc_out4), .flush_fd(flush_fd4),
    .flush_de(flush_de4), .fetch_cnt(fetch_cnt4), .state(state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // fl order: {imem_req, ifu_en, flush_fd, flush_de, ifu_req, ifu_eret}
  task automatic applyStimulus(input string tag, input logic rst, input logic hz,
                               input logic exc, input logic eret, input logic rdy,
                               input logic [31:0] epcv, input logic [2:0] st,
                               input logic [5:0] fl, input logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    hz_stall   = hz;
    exc_req    = exc;
    eret_in    = eret;
    imem_ready = rdy;
    epc        = epcv;
    if (!rst) begin
      exp_cnt = 0;
      exp_epc = 0;
    end
    e.tag = tag;
    e.st  = st;
    e.fl  = fl;
    e.cnt = exp_cnt;
    e.epc = exp_epc;
    sb.push_back(e);
    if (acc) exp_cnt = exp_cnt + 1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput({e.tag, ".state"},    32'(state),      32'(e.st));
      checkOutput({e.tag, ".imem_req"}, 32'(imem_req),   32'(e.fl[5]));
      checkOutput({e.tag, ".ifu_en"},   32'(ifu_en),     32'(e.fl[4]));
      checkOutput({e.tag, ".flush_fd"}, 32'(flush_fd),   32'(e.fl[3]));
      checkOutput({e.tag, ".flush_de"}, 32'(flush_de),   32'(e.fl[2]));
      checkOutput({e.tag, ".ifu_req"},  32'(ifu_req),    32'(e.fl[1]));
      checkOutput({e.tag, ".ifu_eret"}, 32'(ifu_eret),   32'(e.fl[0]));
      checkOutput({e.tag, ".cnt"},      fetch_cnt,       e.cnt);
      checkOutput({e.tag, ".cnt4"},     32'(fetch_cnt4), 32'(e.cnt[3:0]));
      checkOutput({e.tag, ".epc_out"},  epc_out,         e.epc);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; hz_stall = 1'b0; exc_req = 1'b0; eret_in = 1'b0;
    imem_ready = 1'b0; epc = 32'h0;

    applyStimulus("rst0", 0, 0, 0, 0, 0, 32'h0, BOOT, 6'b000000, 0);
    applyStimulus("rst1", 0, 0, 0, 0, 1, 32'h0, BOOT, 6'b000000, 0);
    applyStimulus("rel",  1, 0, 0, 0, 1, 32'h0, BOOT, 6'b000000, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus("run", 1, 0, 0, 0, 1, 32'h0, FETCH, 6'b110000, 1);

    for (int i = 0; i < 3; i++)
      applyStimulus("wait", 1, 0, 0, 0, 0, 32'h0, FETCH, 6'b101000, 0);
    applyStimulus("rdy",    1, 0, 0, 0, 1, 32'h0, FETCH, 6'b110000, 1);
    applyStimulus("stall",  1, 1, 0, 0, 1, 32'h0, FETCH, 6'b100000, 0);
    applyStimulus("hold",   1, 1, 0, 0, 0, 32'h0, HOLD,  6'b000000, 0);
    applyStimulus("unhold", 1, 0, 0, 0, 0, 32'h0, HOLD,  6'b010000, 1);

    applyStimulus("stall2",    1, 1, 0, 0, 1, 32'h0, FETCH, 6'b100000, 0);
    applyStimulus("hold_exc",  1, 1, 1, 0, 0, 32'h0, HOLD,  6'b000000, 0);
    applyStimulus("redir_exc", 1, 1, 1, 0, 1, 32'h0, REDIR, 6'b011110, 0);
    applyStimulus("post_exc",  1, 0, 0, 0, 1, 32'h0, FETCH, 6'b110000, 1);

    applyStimulus("eret_out",  1, 0, 0, 1, 0, 32'h3000, FETCH, 6'b101000, 0);
    exp_epc = 32'h3000;
    applyStimulus("drain_exc", 1, 0, 1, 0, 0, 32'h5555, DRAIN, 6'b101000, 0);
    applyStimulus("drain_rdy", 1, 0, 0, 0, 1, 32'h5555, DRAIN, 6'b101000, 0);
    applyStimulus("redir_ovr", 1, 0, 0, 1, 0, 32'h7777, REDIR, 6'b011110, 0);
    applyStimulus("post_ovr",  1, 0, 0, 0, 1, 32'h0,    FETCH, 6'b110000, 1);

    applyStimulus("eret",       1, 0, 0, 1, 1, 32'h1234, FETCH, 6'b100000, 0);
    exp_epc = 32'h1234;
    applyStimulus("redir_eret", 1, 0, 0, 0, 0, 32'h0,    REDIR, 6'b011101, 0);
    applyStimulus("post_eret",  1, 0, 0, 0, 1, 32'h0,    FETCH, 6'b110000, 1);

    applyStimulus("both",       1, 0, 1, 1, 1, 32'h9999, FETCH, 6'b100000, 0);
    applyStimulus("redir_both", 1, 0, 0, 0, 1, 32'h0,    REDIR, 6'b011110, 0);
    applyStimulus("post_both",  1, 0, 0, 0, 1, 32'h0,    FETCH, 6'b110000, 1);

    for (int i = 0; i < 20; i++)
      applyStimulus("wrap", 1, 0, 0, 0, 1, 32'h0, FETCH, 6'b110000, 1);

    applyStimulus("pre_rst",    1, 0, 1, 0, 0, 32'h0, FETCH, 6'b101000, 0);
    applyStimulus("drain",      1, 0, 0, 0, 0, 32'h0, DRAIN, 6'b101000, 0);
    applyStimulus("rst_mid",    0, 0, 0, 0, 1, 32'h0, BOOT,  6'b000000, 0);
    applyStimulus("rel2",       1, 0, 0, 0, 1, 32'h0, BOOT,  6'b000000, 0);
    applyStimulus("boot_fetch", 1, 0, 0, 0, 1, 32'h0, FETCH, 6'b110000, 1);
    applyStimulus("after",      1, 0, 0, 0, 1, 32'h0, FETCH, 6'b110000, 1);

    @(posedge clk);
    @(posedge clk);
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Fetch-stage sequencer for the instruction fetch unit. It drives the IFU PC enable, exception-entry request and eret strobe, and handshakes with a variable-latency instruction memory. It also arbitrates decode hazard stalls against CP0 redirects and produces the IF/ID and ID/EX flush strobes. It sits between the hazard unit, CP0 and the IFU/imem, and adds a fetch counter for performance monitoring.

## Interface
- CNT_W, 32, width of fetch_cnt
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- hz_stall  in  1  decode hazard stall request
- exc_req  in  1  CP0 exception/interrupt request (M stage), level, sampled each cycle
- eret_in  in  1  eret decoded in D stage
- epc  in  32  EPC from CP0, sampled when eret is accepted
- imem_ready  in  1  instruction memory returns data for the outstanding fetch this cycle
- imem_req  out  1  fetch outstanding / requested
- ifu_en  out  1  IFU PC register enable
- ifu_req  out  1  IFU exception-entry strobe (PC <- 0x0000_4180)
- ifu_eret  out  1  IFU eret strobe
- epc_out  out  32  latched EPC presented to the IFU
- flush_fd  out  1  clear IF/ID register (insert bubble)
- flush_de  out  1  clear ID/EX register
- fetch_cnt  out  CNT_W  count of accepted sequential fetches
- state  out  3  debug state: BOOT=0, FETCH=1, HOLD=2, DRAIN=3, REDIR=4

## Operation
- States: BOOT, FETCH, HOLD, DRAIN, REDIR. A pending-redirect register holds kind (EXC/ERET) and valid.
- BOOT: all outputs 0. Unconditionally go to FETCH next cycle.
- FETCH: imem_req=1.
  - imem_ready & !hz_stall & no redirect: ifu_en=1, fetch_cnt+1, stay in FETCH.
  - imem_ready & hz_stall: ifu_en=0, go to HOLD.
  - !imem_ready: ifu_en=0, flush_fd=1, stay in FETCH.
- HOLD: imem_req=0; the instruction is held in IF/ID. When !hz_stall and no redirect: ifu_en=1, fetch_cnt+1, go to FETCH.
- Redirect acceptance, any state except BOOT/REDIR:
  - exc_req has priority over eret_in.
  - If a fetch is outstanding (FETCH & !imem_ready), latch the pending redirect and go to DRAIN. An outstanding fetch is never aborted.
  - Otherwise go directly to REDIR. Any instruction returned that cycle is discarded, with no ifu_en and no count.
- DRAIN: imem_req=1, flush_fd=1, ifu_en=0.
  - exc_req arriving while pending=ERET overwrites pending to EXC.
  - A repeated exc_req while pending=EXC is ignored.
  - On imem_ready (data discarded), go to REDIR.
- REDIR (one cycle): ifu_en=1, flush_fd=1, flush_de=1.
  - ifu_req=1 if kind=EXC; ifu_eret=1 if kind=ERET. These are mutually exclusive.
  - hz_stall, exc_req and eret_in are ignored. Pending is cleared. Go to FETCH.
- epc_out is loaded from epc on the cycle an eret is accepted and is held otherwise.
- fetch_cnt wraps modulo 2^CNT_W. It never counts in REDIR or on discarded data.
- ifu_en, flush_fd and imem_req are combinational from state and inputs. ifu_req, ifu_eret and flush_de decode state and pending, and are glitch-free from flops.

## Timing
- Reset asserted (low), asynchronously: state=BOOT, pending=0, epc_out=0, fetch_cnt=0, every output 0. This applies at any time, including mid-DRAIN; a pending redirect is lost.
- First imem_req appears 1 cycle after reset deasserts.
- Zero-wait memory: one fetch per cycle, so ifu_en is high every cycle absent stalls.
- Redirect latency with nothing outstanding: exc_req/eret_in at cycle N gives REDIR at N+1 and the first FETCH at N+2.
- With a fetch outstanding: imem_ready at cycle M gives REDIR at M+1.
- exc_req and eret_in in the same cycle: exception taken, eret dropped, epc_out unchanged.
- hz_stall together with a redirect: the redirect wins.

## Test plan
- Reset low mid-run, then release. All outputs are 0 and state=0 during reset. imem_req=1 on the 2nd cycle after release. fetch_cnt=0.
- imem_ready tied 1, no stalls, 10 cycles. ifu_en high for 10 cycles, fetch_cnt=10, flush_fd never asserted.
- imem_ready low for 3 cycles then high. flush_fd=1 for 3 cycles, then ifu_en=1 for 1 cycle, fetch_cnt+1. Then hz_stall=1 with ready: HOLD, ifu_en=0 until hz_stall drops.
- exc_req at cycle N while in HOLD. At N+1: ifu_req=1, ifu_en=1, flush_fd=flush_de=1. At N+2: FETCH, fetch_cnt unchanged.
- eret_in with epc=0x3000 while a fetch is outstanding, then exc_req during DRAIN, then imem_ready. REDIR asserts ifu_req (not ifu_eret), and epc_out=0x3000.
- CNT_W=4: 17 accepted fetches leave fetch_cnt=1 (wrap). exc_req and eret_in in the same cycle give exactly one ifu_req pulse and no ifu_eret.
